seq_multiplier_ctrl: RTL and testbench
======================================

Name: seq_multiplier_ctrl

Overview:
- Parametrised sequential shift-add multiplier: control FSM, step counter and A/B/X/S datapath registers in one block.
- Successor to the fixed 8-bit lab multiplier controller. Width is generic, an operating mode selects signed (two's-complement) or unsigned operation, and a STEP_MODE parameter allows either separate add/shift cycles or a fused add-and-shift cycle.
- Sits between the switch/register front end and the hex-display product readout.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH.
- STEP_MODE, 0. 0 = separate ADD and SHIFT states (2 cycles per bit); 1 = fused ADD+SHIFT in one state (1 cycle per bit).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- Run  in  1  level start request; one operation per high level.
- Signed_Mode  in  1  1 = signed two's-complement, 0 = unsigned; latched at LOAD.
- Multiplicand  in  WIDTH  operand S; latched at LOAD.
- Multiplier  in  WIDTH  operand B; latched at LOAD.
- Busy  out  1  high in LOAD, ADD, SHIFT and STEP.
- Done  out  1  high in DONE.
- Product  out  2*WIDTH  {A,B}; valid while Done is high; holds until the next LOAD.

Behaviour:
- Reset (Reset_n=0, async): state=IDLE; A, B, S, X, cnt, mode all cleared to 0; Busy=0, Done=0, Product=0. Reset mid-operation aborts immediately with no partial result.
- Internal registers: A[WIDTH], B[WIDTH], S[WIDTH], X (1 bit), sgn (latched mode), cnt[clog2(WIDTH)].
- IDLE: when Run=1 at the edge, go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle): A<=0, X<=0, B<=Multiplier, S<=Multiplicand, sgn<=Signed_Mode, cnt<=0. Next state is ADD if STEP_MODE=0, STEP if STEP_MODE=1.
- Add rule, applied in ADD or as the first half of STEP; last = (cnt==WIDTH-1):
  - B[0]=0: {X,A} unchanged.
  - B[0]=1, sgn=1, not last: {X,A} <= sext(A)+sext(S), computed in WIDTH+1 bits.
  - B[0]=1, sgn=1, last: {X,A} <= sext(A)-sext(S), the two's-complement correction for the sign bit.
  - B[0]=1, sgn=0: {X,A} <= zext(A)+zext(S); X = carry out.
- Shift rule, applied in SHIFT or as the second half of STEP: {A,B} <= {X, A, B[WIDTH-1:1]}, shifted right by 1.
  - sgn=1: X is retained (arithmetic shift).
  - sgn=0: X<=0 after the shift.
- cnt increments on each shift. Branch after a shift: if cnt==WIDTH-1 (before the increment), go to DONE; else go to ADD (STEP_MODE=0) or stay in STEP (STEP_MODE=1).
- STEP (STEP_MODE=1 only): add rule and shift rule in the same cycle; the shift uses the post-add {X,A}.
- DONE: Done=1, Product={A,B}. When Run=0 at the edge, go to IDLE. If Run is still held high, no restart occurs.
- Latency, counted from the IDLE edge sampling Run=1 to Done=1:
  - STEP_MODE=0: 2 + 2*WIDTH cycles.
  - STEP_MODE=1: 2 + WIDTH cycles.
- Operand and Signed_Mode changes while Busy=1 are ignored.
- Run dropping while Busy=1 does not abort the operation. Run=0 already sampled when DONE is reached sends the FSM back to IDLE after one cycle in DONE; Done is high for exactly that one cycle.
- Width rules:
  - Signed range: -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2) fits in the 2*WIDTH-bit signed product.
  - Unsigned sum fits in WIDTH+1 bits, so no overflow is possible.
- The default case of the FSM goes to IDLE. All outputs are fully assigned in every state, so no latches are inferred.

Test Plan:
- WIDTH=8, STEP_MODE=0, unsigned, 0xFF*0xFF, pulse Run -> Product=0xFE01; Done first high exactly 18 cycles after the Run sample.
- WIDTH=8, signed, -128*-128 (0x80*0x80) -> Product=0x4000. Signed, 7*-3 (0x07*0xFD) -> Product=0xFFEB. Signed, -1*-1 -> Product=0x0001.
- WIDTH=8, STEP_MODE=1, unsigned, 13*11 -> Product=0x008F, Done after 10 cycles; repeat signed 0x80*0x7F -> Product=0xC080.
- Run held high across DONE for 20 cycles -> exactly one operation, Busy stays 0 in DONE. Then Run low, then high again with new operands 2*3 -> Product=0x0006.
- Change Multiplier and Signed_Mode mid-operation -> result reflects the operands latched at LOAD. Assert Reset_n=0 mid-operation between clock edges -> Busy=0, Done=0, Product=0 immediately; the next run completes correctly.
- WIDTH=4, signed, 0xF*0xF -> Product=0x01; unsigned 0xF*0xF -> Product=0xE1; latencies 10 (STEP_MODE=0) and 6 (STEP_MODE=1).

Source files
------------

// File: rtl/seq_multiplier_ctrl_if.sv
// Operand/control/result bundle for the sequential multiplier.
// The front end drives Run, Signed_Mode and the operands (master); the
// multiplier returns Busy, Done, Product and its state code (slave).
interface seq_multiplier_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 Run;
  logic                 Signed_Mode;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic                 Busy;
  logic                 Done;
  logic [2*WIDTH-1:0]   Product;
  logic [2:0]           state_dbg;

  modport master (
    output Run, Signed_Mode, Multiplicand, Multiplier,
    input  Busy, Done, Product, state_dbg
  );

  modport slave (
    input  Run, Signed_Mode, Multiplicand, Multiplier,
    output Busy, Done, Product, state_dbg
  );
endinterface

// File: rtl/seq_multiplier_ctrl.sv
// Sequential shift-add multiplier: control FSM, step counter and the
// A/B/X/S datapath. Signed mode uses a subtract on the final bit to
// correct for the multiplier sign bit; STEP_MODE=1 fuses add and shift.
//
// Handshake: Run is a level request. An operation starts when Run is
// sampled high in IDLE; Busy is high from LOAD until the last shift, and
// Done is high while the result sits in DONE. The FSM leaves DONE only
// once Run is sampled low, so a held Run never starts a second operation.
// Operands and Signed_Mode are sampled only in LOAD.
module seq_multiplier_ctrl #(
  parameter int WIDTH     = 8,
  parameter int STEP_MODE = 0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  seq_multiplier_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    STEP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             x;
  logic             sgn;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;

  logic             last;
  logic [WIDTH:0]   add_xa;
  logic [WIDTH:0]   sh_src;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             sh_x;

  // Add rule and shift rule as combinational next values for {X,A,B}.
  always_comb begin
    last   = (cnt == CW'(WIDTH - 1));
    add_xa = {x, a};
    if (b[0]) begin
      if (sgn) begin
        if (last) add_xa = {a[WIDTH-1], a} - {s[WIDTH-1], s};
        else      add_xa = {a[WIDTH-1], a} + {s[WIDTH-1], s};
      end else begin
        add_xa = {1'b0, a} + {1'b0, s};
      end
    end
    // The fused step shifts the freshly added value; SHIFT uses the registers.
    sh_src = (state == STEP) ? add_xa : {x, a};
    sh_a   = {sh_src[WIDTH], sh_src[WIDTH-1:1]};
    sh_b   = {sh_src[0], b[WIDTH-1:1]};
    sh_x   = sgn ? sh_src[WIDTH] : 1'b0;
  end

  // Control FSM with datapath registers and registered Busy/Done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      s     <= '0;
      x     <= 1'b0;
      sgn   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Run) begin
            state <= LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        LOAD: begin
          a     <= '0;
          x     <= 1'b0;
          b     <= bus.Multiplier;
          s     <= bus.Multiplicand;
          sgn   <= bus.Signed_Mode;
          cnt   <= '0;
          state <= (STEP_MODE != 0) ? STEP : ADD;
        end
        ADD: begin
          {x, a} <= add_xa;
          state  <= SHIFT;
        end
        SHIFT, STEP: begin
          a   <= sh_a;
          b   <= sh_b;
          x   <= sh_x;
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= (state == STEP) ? STEP : ADD;
          end
        end
        DONE: begin
          if (!bus.Run) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.Product   = {a, b};
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Bench for seq_multiplier_ctrl: four instances (WIDTH 8/4 x STEP_MODE 0/1)
// driven from a table of hand-computed products and latencies, plus
// sequences for held Run, mid-operation operand changes and async reset.
// Latency = rising edges from the edge that samples Run=1 (counted as 1)
// through the edge that raises Done.
module tb_seq_multiplier_ctrl;

  logic Clk;
  logic Reset_n;

  seq_multiplier_ctrl_if #(.WIDTH(8)) if_a ();
  seq_multiplier_ctrl_if #(.WIDTH(8)) if_b ();
  seq_multiplier_ctrl_if #(.WIDTH(4)) if_c ();
  seq_multiplier_ctrl_if #(.WIDTH(4)) if_d ();

  seq_multiplier_ctrl #(.WIDTH(8), .STEP_MODE(0)) u_a (.Clk(Clk), .Reset_n(Reset_n), .bus(if_a));
  seq_multiplier_ctrl #(.WIDTH(8), .STEP_MODE(1)) u_b (.Clk(Clk), .Reset_n(Reset_n), .bus(if_b));
  seq_multiplier_ctrl #(.WIDTH(4), .STEP_MODE(0)) u_c (.Clk(Clk), .Reset_n(Reset_n), .bus(if_c));
  seq_multiplier_ctrl #(.WIDTH(4), .STEP_MODE(1)) u_d (.Clk(Clk), .Reset_n(Reset_n), .bus(if_d));

  int checks = 0;
  int errors = 0;
  int lat_g  = 0;

  typedef struct {
    int         d;
    logic       sg;
    logic [7:0] mc;
    logic [7:0] mp;
    logic [15:0] exp_p;
    int         exp_lat;
  } vec_t;

  vec_t vecs[15];

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int d, input logic sg, input logic [7:0] mc, input logic [7:0] mp);
    case (d)
      0: begin if_a.Signed_Mode = sg; if_a.Multiplicand = mc;      if_a.Multiplier = mp;      end
      1: begin if_b.Signed_Mode = sg; if_b.Multiplicand = mc;      if_b.Multiplier = mp;      end
      2: begin if_c.Signed_Mode = sg; if_c.Multiplicand = mc[3:0]; if_c.Multiplier = mp[3:0]; end
      default: begin if_d.Signed_Mode = sg; if_d.Multiplicand = mc[3:0]; if_d.Multiplier = mp[3:0]; end
    endcase
  endtask

  task automatic set_run(input int d, input logic r);
    case (d)
      0: if_a.Run = r;
      1: if_b.Run = r;
      2: if_c.Run = r;
      default: if_d.Run = r;
    endcase
  endtask

  function automatic logic get_done(input int d);
    case (d)
      0: return if_a.Done;
      1: return if_b.Done;
      2: return if_c.Done;
      default: return if_d.Done;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0: return if_a.Busy;
      1: return if_b.Busy;
      2: return if_c.Busy;
      default: return if_d.Busy;
    endcase
  endfunction

  function automatic logic [15:0] get_prod(input int d);
    case (d)
      0: return if_a.Product;
      1: return if_b.Product;
      2: return {8'h00, if_c.Product};
      default: return {8'h00, if_d.Product};
    endcase
  endfunction

  // Driver: present operands with Run high, let the sampling edge pass.
  task automatic start_op(input int d, input logic sg, input logic [7:0] mc,
                          input logic [7:0] mp, input logic keep_run);
    @(negedge Clk);
    set_ops(d, sg, mc, mp);
    set_run(d, 1'b1);
    @(posedge Clk);
    #1;
    lat_g = 1;
    if (!keep_run) set_run(d, 1'b0);
  endtask

  // Bounded wait for Done; a timeout leaves lat_g at 100 and fails the latency check.
  task automatic wait_done(input int d);
    while (!get_done(d) && lat_g < 100) begin
      @(posedge Clk);
      #1;
      lat_g++;
    end
  endtask

  task automatic run_op(input string name, input int d, input logic sg, input logic [7:0] mc,
                        input logic [7:0] mp, input logic [15:0] exp_p, input int exp_lat);
    start_op(d, sg, mc, mp, 1'b0);
    wait_done(d);
    check({name, "_prod"}, 32'(get_prod(d)), 32'(exp_p));
    check({name, "_lat"}, 32'(lat_g), 32'(exp_lat));
    @(posedge Clk);
    #1;
    check({name, "_done_pulse"}, 32'(get_done(d)), 32'd0);
  endtask

  initial begin
    int viol;

    vecs[0]  = '{0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 18};
    vecs[1]  = '{0, 1'b1, 8'h80, 8'h80, 16'h4000, 18};
    vecs[2]  = '{0, 1'b1, 8'h07, 8'hFD, 16'hFFEB, 18};
    vecs[3]  = '{0, 1'b1, 8'hFF, 8'hFF, 16'h0001, 18};
    vecs[4]  = '{0, 1'b0, 8'h00, 8'h5A, 16'h0000, 18};
    vecs[5]  = '{0, 1'b0, 8'h80, 8'h02, 16'h0100, 18};
    vecs[6]  = '{1, 1'b0, 8'h0D, 8'h0B, 16'h008F, 10};
    vecs[7]  = '{1, 1'b1, 8'h80, 8'h7F, 16'hC080, 10};
    vecs[8]  = '{1, 1'b1, 8'h7F, 8'h7F, 16'h3F01, 10};
    vecs[9]  = '{2, 1'b1, 8'h0F, 8'h0F, 16'h0001, 10};
    vecs[10] = '{2, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 10};
    vecs[11] = '{2, 1'b1, 8'h08, 8'h08, 16'h0040, 10};
    vecs[12] = '{3, 1'b1, 8'h0F, 8'h0F, 16'h0001, 6};
    vecs[13] = '{3, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 6};
    vecs[14] = '{3, 1'b1, 8'h07, 8'h08, 16'h00C8, 6};

    // Reset
    Reset_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      set_run(d, 1'b0);
      set_ops(d, 1'b0, 8'h00, 8'h00);
    end
    repeat (3) @(posedge Clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_busy%0d", d), 32'(get_busy(d)), 32'd0);
      check($sformatf("rst_done%0d", d), 32'(get_done(d)), 32'd0);
      check($sformatf("rst_prod%0d", d), 32'(get_prod(d)), 32'd0);
    end
    @(negedge Clk);
    Reset_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].d, vecs[i].sg, vecs[i].mc, vecs[i].mp,
             vecs[i].exp_p, vecs[i].exp_lat);
    end

    // Run held high across DONE: single operation, Busy stays low
    start_op(0, 1'b0, 8'h05, 8'h04, 1'b1);
    wait_done(0);
    check("hold_prod", 32'(get_prod(0)), 32'h0014);
    check("hold_lat", 32'(lat_g), 32'd18);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      #1;
      if (!get_done(0) || get_busy(0) || get_prod(0) != 16'h0014) viol++;
    end
    check("hold_no_restart", 32'(viol), 32'd0);
    @(negedge Clk);
    set_run(0, 1'b0);
    @(posedge Clk);
    #1;
    check("hold_release_done", 32'(get_done(0)), 32'd0);
    run_op("rerun", 0, 1'b0, 8'h02, 8'h03, 16'h0006, 18);

    // Operand and mode changes while busy are ignored
    start_op(0, 1'b0, 8'h0C, 8'h0A, 1'b0);
    repeat (3) begin
      @(posedge Clk);
      #1;
      lat_g++;
    end
    set_ops(0, 1'b1, 8'h99, 8'hFF);
    check("mid_busy", 32'(get_busy(0)), 32'd1);
    wait_done(0);
    check("mid_prod", 32'(get_prod(0)), 32'h0078);
    check("mid_lat", 32'(lat_g), 32'd18);
    @(posedge Clk);
    #1;

    // Async reset between edges aborts with no partial result
    start_op(0, 1'b0, 8'h12, 8'h34, 1'b0);
    repeat (5) @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(get_busy(0)), 32'd0);
    check("arst_done", 32'(get_done(0)), 32'd0);
    check("arst_prod", 32'(get_prod(0)), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op("post_rst", 0, 1'b0, 8'h12, 8'h34, 16'h03A8, 18);

    // Report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
